eth_rx_frame_buffer: RTL and testbench

Receive-side frame buffer placed directly downstream of the MAC's RX AXI-stream output (`rx_axis_mac_*`) in the `clk_mac` domain. It filters frames by destination MAC address and discards frames flagged bad by `tuser`, runts and frames that overflow storage. Only complete, good frames are released to a back-pressurable AXI-stream consumer. The MAC RX side has no `tready`, so every input beat is accepted unconditionally.

---
 rtl/eth_rx_frame_buffer_pkg.sv | 34 +++
 rtl/eth_rx_frame_buffer_ram.sv | 29 ++
 rtl/eth_rx_frame_buffer.sv | 195 +++++++++++++++++++
 tb/tb_eth_rx_frame_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_frame_buffer_pkg.sv
// Shared types and constants for the Ethernet RX frame buffer:
// write-FSM states, drop reasons, address constants and small helpers.
package eth_rx_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_HDR,
      RX_BODY,
      RX_DROP
   } rx_state_t;

   typedef enum logic [1:0] {
      DROP_NONE,
      DROP_ADDR,
      DROP_ERR,
      DROP_OVF
   } drop_reason_t;

   localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
   localparam int          ETH_ADDR_BYTES = 6;

   // Byte idx of a MAC address, byte 0 being the first on the wire (bits [47:40]).
   function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] idx);
      logic [47:0] sh;
      sh = addr << (8 * idx);
      return sh[47:40];
   endfunction

   // Saturating 16-bit increment for the statistics counters.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/eth_rx_frame_buffer_ram.sv
// Simple dual-port RAM, 9 bits wide ({last, data}), registered read.
// No reset on the array or read register so it maps onto block RAM.
import eth_rx_pkg::*;

module eth_rx_ram #(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [8:0]    wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [8:0]    rd_data
);

   logic [8:0] mem [0:(1<<AW)-1];

   // Write port.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read port; output register holds its value when no read is issued.
   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Ethernet RX frame buffer: stores MAC RX bytes, filters by destination
// address, discards errored/runt/overflowing frames and releases only
// complete good frames to a back-pressurable AXI-stream consumer.
// Optional statistics counters are built when ETH_RX_STATS_EN is defined.
import eth_rx_pkg::*;

module eth_rx_frame_buffer #(
   parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
   parameter int          DEPTH_LOG2 = 11
) (
   input  logic        clk_mac,
   input  logic        rst_n,
   input  logic        promisc,
   input  logic [7:0]  s_tdata,
   input  logic        s_tvalid,
   input  logic        s_tlast,
   input  logic        s_tuser,
   output logic [7:0]  m_tdata,
   output logic        m_tvalid,
   output logic        m_tlast,
   input  logic        m_tready,
   output logic [15:0] cnt_ok,
   output logic [15:0] cnt_drop_addr,
   output logic [15:0] cnt_drop_err,
   output logic [15:0] cnt_drop_ovf
);

   localparam logic [2:0] LAST_HDR = 3'(ETH_ADDR_BYTES - 1);

   // Pointers
   logic [DEPTH_LOG2-1:0] wr_ptr, wr_commit, rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr_inc;
   logic                  full, avail;

   // Write FSM
   rx_state_t    state, state_nxt;
   logic [2:0]   byte_idx, idx_nxt;
   logic         addr_uc, addr_bc, uc_nxt, bc_nxt;
   logic         in_hdr, uc_hit, bc_hit;
   logic [2:0]   cur_idx;
   logic         wr_en, commit;
   drop_reason_t drop;

   // Read side
   logic       rd_en, rd_pend, load;
   logic [8:0] rd_q;

   assign wr_ptr_inc = wr_ptr + 1'b1;
   assign full       = (wr_ptr_inc == rd_ptr);
   assign avail      = (rd_ptr != wr_commit);

   // The first beat of a frame is byte 0 and has no previous match history.
   assign in_hdr  = (state == RX_IDLE) || (state == RX_HDR);
   assign cur_idx = (state == RX_IDLE) ? 3'd0 : byte_idx;
   assign uc_hit  = ((state == RX_IDLE) || addr_uc) &&
                    (s_tdata == addr_byte(MAC_ADDR, cur_idx));
   assign bc_hit  = ((state == RX_IDLE) || addr_bc) &&
                    (s_tdata == addr_byte(ETH_BCAST_ADDR, cur_idx));

   // Write FSM next state, drop decision and write/commit strobes.
   always_comb begin
      state_nxt = state;
      idx_nxt   = byte_idx;
      uc_nxt    = addr_uc;
      bc_nxt    = addr_bc;
      wr_en     = 1'b0;
      commit    = 1'b0;
      drop      = DROP_NONE;
      if (s_tvalid) begin
         if (state == RX_DROP) begin
            if (s_tlast) state_nxt = RX_IDLE;
         end else begin
            if (full)
               drop = DROP_OVF;
            else if (s_tuser)
               drop = DROP_ERR;
            else if (in_hdr && s_tlast && (cur_idx < LAST_HDR))
               drop = DROP_ERR;   // runt
            else if (in_hdr && (cur_idx == LAST_HDR) && !(uc_hit || bc_hit || promisc))
               drop = DROP_ADDR;

            if (drop != DROP_NONE) begin
               state_nxt = s_tlast ? RX_IDLE : RX_DROP;
            end else begin
               wr_en = 1'b1;
               if (s_tlast) begin
                  commit    = 1'b1;
                  state_nxt = RX_IDLE;
               end else if (in_hdr) begin
                  if (cur_idx == LAST_HDR) begin
                     state_nxt = RX_BODY;
                  end else begin
                     state_nxt = RX_HDR;
                     idx_nxt   = cur_idx + 3'd1;
                     uc_nxt    = uc_hit;
                     bc_nxt    = bc_hit;
                  end
               end
            end
         end
      end
   end

   // Write FSM state and write-side pointers; a drop rewinds to the last commit.
   always_ff @(posedge clk_mac) begin
      if (!rst_n) begin
         state     <= RX_IDLE;
         byte_idx  <= 3'd0;
         addr_uc   <= 1'b0;
         addr_bc   <= 1'b0;
         wr_ptr    <= '0;
         wr_commit <= '0;
      end else begin
         state    <= state_nxt;
         byte_idx <= idx_nxt;
         addr_uc  <= uc_nxt;
         addr_bc  <= bc_nxt;
         if (drop != DROP_NONE)
            wr_ptr <= wr_commit;
         else if (wr_en)
            wr_ptr <= wr_ptr_inc;
         if (commit)
            wr_commit <= wr_ptr_inc;
      end
   end

   eth_rx_ram #(.AW(DEPTH_LOG2)) u_ram (
      .clk     (clk_mac),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data ({s_tlast, s_tdata}),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr),
      .rd_data (rd_q)
   );

   // The RAM output register acts as a one-entry skid stage behind the
   // prefetch register, so a read is issued whenever that stage will be free.
   assign load  = rd_pend && (!m_tvalid || m_tready);
   assign rd_en = avail && (!rd_pend || load);

   // Read pointer, pending-read flag and output prefetch register.
   always_ff @(posedge clk_mac) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         rd_pend  <= 1'b0;
         m_tvalid <= 1'b0;
         m_tdata  <= 8'd0;
         m_tlast  <= 1'b0;
      end else begin
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         rd_pend <= rd_en || (rd_pend && !load);
         if (load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= rd_q[7:0];
            m_tlast  <= rd_q[8];
         end else if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
         end
      end
   end

`ifdef ETH_RX_STATS_EN
   logic [15:0] ok_q, addr_q, err_q, ovf_q;

   // Per-frame event counters, saturating.
   always_ff @(posedge clk_mac) begin
      if (!rst_n) begin
         ok_q   <= 16'd0;
         addr_q <= 16'd0;
         err_q  <= 16'd0;
         ovf_q  <= 16'd0;
      end else begin
         if (commit) ok_q <= sat_inc(ok_q);
         case (drop)
            DROP_ADDR: addr_q <= sat_inc(addr_q);
            DROP_ERR:  err_q  <= sat_inc(err_q);
            DROP_OVF:  ovf_q  <= sat_inc(ovf_q);
            default: ;
         endcase
      end
   end

   assign cnt_ok        = ok_q;
   assign cnt_drop_addr = addr_q;
   assign cnt_drop_err  = err_q;
   assign cnt_drop_ovf  = ovf_q;
`else
   assign cnt_ok        = 16'd0;
   assign cnt_drop_addr = 16'd0;
   assign cnt_drop_err  = 16'd0;
   assign cnt_drop_ovf  = 16'd0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Bench for eth_rx_frame_buffer: directed frames, an expected-byte queue
// filled from the frame-acceptance rules, and a per-cycle output checker.
module tb_eth_rx_frame_buffer;
   import eth_rx_pkg::*;

   localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
   localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
   localparam logic [47:0] BC    = 48'hFFFF_FFFF_FFFF;
`ifdef ETH_RX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk_mac = 1'b0;
   logic        rst_n   = 1'b0;
   logic        promisc = 1'b0;
   logic [7:0]  s_tdata = 8'd0;
   logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tlast;
   logic        m_tready = 1'b1;
   logic [15:0] cnt_ok, cnt_drop_addr, cnt_drop_err, cnt_drop_ovf;

   int n_checks = 0;
   int n_pass   = 0;
   int n_out    = 0;
   logic [8:0] exp_q[$];
   logic       hold_prev = 1'b0;
   logic [8:0] prev_beat = 9'd0;
   logic [8:0] exp_beat;

   eth_rx_frame_buffer #(.MAC_ADDR(MAC), .DEPTH_LOG2(7)) dut (
      .clk_mac(clk_mac), .rst_n(rst_n), .promisc(promisc),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .cnt_ok(cnt_ok), .cnt_drop_addr(cnt_drop_addr),
      .cnt_drop_err(cnt_drop_err), .cnt_drop_ovf(cnt_drop_ovf)
   );

   always #10 clk_mac = ~clk_mac;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk_mac); #1;
   endtask

   function automatic logic [7:0] byte_at(input logic [47:0] da, input logic [7:0] base, input int i);
      if (i < 6) return da[47 - 8*i -: 8];
      return base + 8'(i * 3);
   endfunction

   task automatic beat(input logic [7:0] d, input logic last, input logic user);
      s_tvalid = 1'b1; s_tdata = d; s_tlast = last; s_tuser = user;
      tick();
   endtask

   // Sends a frame back-to-back; returns #1 after the edge sampling tlast.
   // A frame is expected on the output only if it passes every acceptance rule.
   task automatic send_frame(input logic [47:0] da, input int len, input logic [7:0] base,
                             input int err_at, input bit exp_ovf);
      bit good;
      for (int i = 0; i < len; i++)
         beat(byte_at(da, base, i), i == len - 1, i == err_at);
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      good = !exp_ovf && (err_at < 0) && (len >= 6) && (da == MAC || da == BC || promisc);
      if (good)
         for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, byte_at(da, base, i)});
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || m_tvalid) && t < 2000) begin tick(); t++; end
      chk("drain_done", 32'(t < 2000), 32'd1);
      repeat (4) tick();
   endtask

   task automatic check_cnt(input int ok, input int ad, input int er, input int ov);
      chk("cnt_ok",        32'(cnt_ok),        STATS ? 32'(ok) : 32'd0);
      chk("cnt_drop_addr", 32'(cnt_drop_addr), STATS ? 32'(ad) : 32'd0);
      chk("cnt_drop_err",  32'(cnt_drop_err),  STATS ? 32'(er) : 32'd0);
      chk("cnt_drop_ovf",  32'(cnt_drop_ovf),  STATS ? 32'(ov) : 32'd0);
   endtask

   // Output checker: every accepted beat must be the next expected byte, and a
   // stalled beat must hold its data.
   always @(negedge clk_mac) begin
      if (!rst_n) begin
         hold_prev <= 1'b0;
      end else begin
         if (hold_prev)
            chk("hold_stable", {22'd0, m_tvalid, m_tlast, m_tdata}, {22'd0, 1'b1, prev_beat});
         if (m_tvalid && m_tready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {23'd0, m_tlast, m_tdata}, 32'h1ff_ffff);
            end else begin
               exp_beat = exp_q.pop_front();
               chk("out_beat", {23'd0, m_tlast, m_tdata}, {23'd0, exp_beat});
            end
         end
         hold_prev <= m_tvalid && !m_tready;
         prev_beat <= {m_tlast, m_tdata};
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base_out;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      // Reset state
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_m_tdata",  32'(m_tdata),  32'd0);
      chk("rst_m_tlast",  32'(m_tlast),  32'd0);
      check_cnt(0, 0, 0, 0);

      // Broadcast 64 bytes: latency and ordered delivery
      base_out = n_out;
      send_frame(BC, 64, 8'h10, -1, 0);
      tick();
      chk("lat_n1_tvalid", 32'(m_tvalid), 32'd0);
      tick();
      chk("lat_n2_tvalid", 32'(m_tvalid), 32'd1);
      chk("first_byte_ff", 32'(m_tdata), 32'hff);
      drain();
      chk("bc_len", 32'(n_out - base_out), 32'd64);
      check_cnt(1, 0, 0, 0);

      // Foreign address dropped, then accepted in promiscuous mode
      base_out = n_out;
      send_frame(OTHER, 64, 8'h20, -1, 0);
      drain();
      chk("addr_drop_len", 32'(n_out - base_out), 32'd0);
      check_cnt(1, 1, 0, 0);
      promisc = 1'b1;
      base_out = n_out;
      send_frame(OTHER, 64, 8'h30, -1, 0);
      drain();
      chk("promisc_len", 32'(n_out - base_out), 32'd64);
      check_cnt(2, 1, 0, 0);
      promisc = 1'b0;

      // Errored frame immediately followed by a good one
      base_out = n_out;
      send_frame(MAC, 60, 8'h40, 59, 0);
      send_frame(MAC, 60, 8'h41, -1, 0);
      drain();
      chk("err_then_good_len", 32'(n_out - base_out), 32'd60);
      check_cnt(3, 1, 1, 0);

      // Overflow: 128-byte buffer, consumer stalled, third frame does not fit
      m_tready = 1'b0;
      send_frame(MAC, 60, 8'h50, -1, 0);
      send_frame(MAC, 60, 8'h51, -1, 0);
      send_frame(MAC, 60, 8'h52, -1, 1);
      repeat (5) tick();
      chk("ovf_stalled_valid", 32'(m_tvalid), 32'd1);
      check_cnt(5, 1, 1, 1);
      base_out = n_out;
      m_tready = 1'b1;
      drain();
      chk("ovf_out_len", 32'(n_out - base_out), 32'd120);

      // Runt followed by a good frame
      base_out = n_out;
      send_frame(MAC, 4, 8'h60, -1, 0);
      send_frame(MAC, 64, 8'h61, -1, 0);
      drain();
      chk("runt_then_good_len", 32'(n_out - base_out), 32'd64);
      check_cnt(6, 1, 2, 1);

      // Reset during byte 30 with a committed, unread frame in the buffer
      m_tready = 1'b0;
      send_frame(MAC, 60, 8'h70, -1, 0);
      repeat (5) tick();
      for (int i = 0; i < 30; i++) beat(byte_at(MAC, 8'h71, i), 1'b0, 1'b0);
      s_tvalid = 1'b1; s_tdata = byte_at(MAC, 8'h71, 30); rst_n = 1'b0;
      tick();
      chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("midrst_m_tdata",  32'(m_tdata),  32'd0);
      chk("midrst_m_tlast",  32'(m_tlast),  32'd0);
      check_cnt(0, 0, 0, 0);
      rst_n = 1'b1; s_tvalid = 1'b0;
      exp_q.delete();
      m_tready = 1'b1;
      repeat (4) tick();
      chk("post_rst_idle", 32'(m_tvalid), 32'd0);
      base_out = n_out;
      send_frame(MAC, 64, 8'h80, -1, 0);
      drain();
      chk("post_rst_len", 32'(n_out - base_out), 32'd64);
      check_cnt(1, 0, 0, 0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
